// File: rtl/ram_cache_line.sv
// ram_cache_line
// ---------------------------------------------------------------------------
// Single-entry write-back / write-allocate cache leaf. It holds one aligned
// xlen-bit word with its tag, valid and dirty state. Hits are answered
// combinationally. Misses and dirty flushes go through a ready-handshaked
// port to the next memory level.
//
// Ports
//   clock                  sole clock, state updates on posedge
//   reset                  asynchronous active-low clear of all state
//   ram_input_load/store/flush  request strobes (flush > store > load)
//   ram_input_address      byte address, low ob bits ignored
//   ram_input_store_value  store data
//   ram_input_store_mask   byte enables for stores
//   address_in_cache       valid and stored tag matches the request tag
//   busy                   request cannot complete this cycle
//   load_value             stored data word
//   mem_read / mem_write   fill / writeback request to backing memory
//   mem_address            {tag, ob zeros} of the current memory request
//   mem_write_value        stored data word (writeback data)
//   mem_read_value         fill data, sampled on the ready edge
//   mem_ready              memory completes the current request this cycle
// ---------------------------------------------------------------------------
module ram_cache_line #(
    parameter bit rv64 = 1'b1,
    localparam int XLEN = rv64 ? 64 : 32,
    localparam int OB   = rv64 ? 3 : 2,
    localparam int TW   = XLEN - OB
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ram_input_load,
    input  logic              ram_input_store,
    input  logic              ram_input_flush,
    input  logic [XLEN-1:0]   ram_input_address,
    input  logic [XLEN-1:0]   ram_input_store_value,
    input  logic [XLEN/8-1:0] ram_input_store_mask,
    output logic              address_in_cache,
    output logic              busy,
    output logic [XLEN-1:0]   load_value,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_write_value,
    input  logic [XLEN-1:0]   mem_read_value,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            valid_r;
    logic            dirty_r;
    logic            fill_pend_r;
    logic [TW-1:0]   tag_r;
    logic [TW-1:0]   fill_tag_r;
    logic [XLEN-1:0] data_r;

    logic [TW-1:0]   addr_tag_s;
    logic            hit_s;
    logic            req_s;
    logic            do_store_s;
    logic            start_miss_s;
    logic            start_flush_s;
    logic            wb_done_s;
    logic            fill_done_s;
    logic            unused_addr_bits_s;

    // Byte-wise merge of store data into the held word under the mask.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0]   old_word,
        input logic [XLEN-1:0]   new_word,
        input logic [XLEN/8-1:0] mask
    );
        logic [XLEN-1:0] result;
        result = old_word;
        for (int i = 0; i < XLEN / 8; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign addr_tag_s         = ram_input_address[XLEN-1:OB];
    assign unused_addr_bits_s = ^ram_input_address[OB-1:0];
    assign req_s              = ram_input_load | ram_input_store;

    // The line is never reported present while it is being refilled.
    assign hit_s = valid_r && (tag_r == addr_tag_s) && (state_r != ST_FILL);

    assign address_in_cache = hit_s;
    assign load_value       = data_r;
    assign mem_write_value  = data_r;

    // Next-state, busy and memory-port decode.
    always_comb begin
        next_state_s  = state_r;
        busy          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {tag_r, {OB{1'b0}}};
        do_store_s    = 1'b0;
        start_miss_s  = 1'b0;
        start_flush_s = 1'b0;
        wb_done_s     = 1'b0;
        fill_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ram_input_flush) begin
                    if (valid_r && dirty_r) begin
                        busy          = 1'b1;
                        start_flush_s = 1'b1;
                        next_state_s  = ST_WRITEBACK;
                    end else begin
                        busy = 1'b0;
                    end
                end else if (req_s) begin
                    if (hit_s) begin
                        do_store_s = ram_input_store;
                    end else begin
                        busy         = 1'b1;
                        start_miss_s = 1'b1;
                        next_state_s = (valid_r && dirty_r) ? ST_WRITEBACK : ST_FILL;
                    end
                end else begin
                    busy = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                if (mem_ready) begin
                    wb_done_s    = 1'b1;
                    // A pending fill means this writeback was a miss eviction.
                    next_state_s = fill_pend_r ? ST_FILL : ST_IDLE;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_FILL: begin
                mem_read    = 1'b1;
                busy        = 1'b1;
                mem_address = {fill_tag_r, {OB{1'b0}}};
                if (mem_ready) begin
                    fill_done_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Line contents: tag, data, valid/dirty and the pending fill target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r     <= 1'b0;
            dirty_r     <= 1'b0;
            fill_pend_r <= 1'b0;
            tag_r       <= {TW{1'b0}};
            fill_tag_r  <= {TW{1'b0}};
            data_r      <= {XLEN{1'b0}};
        end else if (fill_done_s) begin
            data_r      <= mem_read_value;
            tag_r       <= fill_tag_r;
            valid_r     <= 1'b1;
            dirty_r     <= 1'b0;
            fill_pend_r <= 1'b0;
        end else if (wb_done_s) begin
            dirty_r <= 1'b0;
        end else if (start_miss_s) begin
            fill_tag_r  <= addr_tag_s;
            fill_pend_r <= 1'b1;
        end else if (start_flush_s) begin
            fill_pend_r <= 1'b0;
        end else if (do_store_s) begin
            data_r  <= merge_bytes(data_r, ram_input_store_value, ram_input_store_mask);
            dirty_r <= 1'b1;
        end else begin
            dirty_r <= dirty_r;
        end
    end

endmodule

// File: tb/tb_ram_cache_line.sv
// Testbench for ram_cache_line (rv64 = 0). Directed scenarios followed by
// randomized requests, checked against a line/memory model kept here.
module tb_ram_cache_line;

    logic        clock = 1'b0;
    logic        reset;
    logic        ram_input_load;
    logic        ram_input_store;
    logic        ram_input_flush;
    logic [31:0] ram_input_address;
    logic [31:0] ram_input_store_value;
    logic [3:0]  ram_input_store_mask;
    logic        address_in_cache;
    logic        busy;
    logic [31:0] load_value;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_value;
    logic [31:0] mem_read_value;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: the line and the backing memory (word-indexed).
    bit          m_valid;
    bit          m_dirty;
    logic [29:0] m_tag;
    logic [31:0] m_data;
    logic [31:0] mem [logic [29:0]];

    always #5 clock = ~clock;

    ram_cache_line #(.rv64(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .ram_input_load(ram_input_load),
        .ram_input_store(ram_input_store),
        .ram_input_flush(ram_input_flush),
        .ram_input_address(ram_input_address),
        .ram_input_store_value(ram_input_store_value),
        .ram_input_store_mask(ram_input_store_mask),
        .address_in_cache(address_in_cache),
        .busy(busy),
        .load_value(load_value),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_write_value(mem_write_value),
        .mem_read_value(mem_read_value),
        .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] k);
        if (mem.exists(k)) return mem[k];
        return {k, 2'b11} ^ 32'h5EED_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // strb = {flush, store, load}. Drives one request, acts as backing memory
    // with 'waits' not-ready cycles per memory request, and checks it.
    task automatic run_op(input logic [2:0] strb, input logic [31:0] addr,
                          input logic [31:0] val, input logic [3:0] msk, input int waits);
        logic [29:0] k;
        bit          is_flush, is_mem, is_store, exp_wb, exp_fill;
        logic [31:0] exp_wb_addr, exp_wb_data, exp_fill_addr, exp_load;
        int          exp_lat, cyc, wcnt, nwb, nfill;
        k        = addr[31:2];
        is_flush = strb[2];
        is_mem   = !strb[2] && (strb[1] || strb[0]);
        is_store = !strb[2] && strb[1];
        exp_wb   = 1'b0;
        exp_fill = 1'b0;
        if (is_flush) begin
            exp_wb = m_valid && m_dirty;
        end else if (is_mem && !(m_valid && m_tag == k)) begin
            exp_fill = 1'b1;
            exp_wb   = m_valid && m_dirty;
        end
        exp_wb_addr   = {m_tag, 2'b00};
        exp_wb_data   = m_data;
        exp_fill_addr = {k, 2'b00};
        exp_lat = (exp_wb ? waits + 1 : 0) + (exp_fill ? waits + 1 : 0) + ((exp_wb || exp_fill) ? 1 : 0);
        if (exp_wb) begin
            mem[m_tag] = m_data;
            m_dirty    = 1'b0;
        end
        if (exp_fill) begin
            m_data  = mem_rd(k);
            m_tag   = k;
            m_valid = 1'b1;
            m_dirty = 1'b0;
        end
        exp_load = m_data;
        if (is_store) begin
            m_data  = merge(m_data, val, msk);
            m_dirty = 1'b1;
        end

        ram_input_flush       = strb[2];
        ram_input_store       = strb[1];
        ram_input_load        = strb[0];
        ram_input_address     = addr;
        ram_input_store_value = val;
        ram_input_store_mask  = msk;
        cyc = 0; wcnt = 0; nwb = 0; nfill = 0;
        while (1) begin
            @(negedge clock);
            if (!busy) break;
            if (cyc >= 60) begin
                chk("timeout", cyc, exp_lat);
                break;
            end
            cyc++;
            chk("rd_wr_excl", mem_read && mem_write, 1'b0);
            if (mem_write) begin
                chk("wb_addr", mem_address, exp_wb_addr);
                chk("wb_data", mem_write_value, exp_wb_data);
                if (wcnt == waits) begin
                    mem_ready = 1'b1; nwb++; wcnt = 0;
                end else wcnt++;
            end else if (mem_read) begin
                chk("fill_addr", mem_address, exp_fill_addr);
                chk("fill_nohit", address_in_cache, 1'b0);
                if (wcnt == waits) begin
                    mem_ready = 1'b1; nfill++; wcnt = 0;
                    mem_read_value = mem_rd(mem_address[31:2]);
                end else wcnt++;
            end
            @(posedge clock);
            #1;
            mem_ready      = 1'b0;
            mem_read_value = $urandom;
        end
        chk("latency", cyc, exp_lat);
        chk("n_writeback", nwb, exp_wb);
        chk("n_fill", nfill, exp_fill);
        chk("idle_rd", mem_read, 1'b0);
        chk("idle_wr", mem_write, 1'b0);
        if (is_mem) begin
            chk("hit", address_in_cache, 1'b1);
            chk("load_value", load_value, exp_load);
        end
        @(posedge clock);
        #1;
        ram_input_flush = 1'b0;
        ram_input_store = 1'b0;
        ram_input_load  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ram_input_load = 1'b0; ram_input_store = 1'b0; ram_input_flush = 1'b0;
        ram_input_address = 32'h0; ram_input_store_value = 32'h0; ram_input_store_mask = 4'h0;
        mem_read_value = 32'h0; mem_ready = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_tag = 30'h0; m_data = 32'h0;
        mem[30'h40] = 32'hCAFEF00D;

        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", mem_read, 1'b0);
        chk("rst_wr", mem_write, 1'b0);
        chk("rst_hit", address_in_cache, 1'b0);
        chk("rst_data", load_value, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Clean miss then hits, store merge, dirty miss with slow memory.
        run_op(3'b001, 32'h100, 32'h0, 4'h0, 0);
        chk("plan_fill_val", load_value, 32'hCAFEF00D);
        run_op(3'b010, 32'h100, 32'h0000_00AA, 4'b0001, 0);
        run_op(3'b001, 32'h100, 32'h0, 4'h0, 0);
        chk("plan_merged", load_value, 32'hCAFEF0AA);
        run_op(3'b001, 32'h200, 32'h0, 4'h0, 2);

        // Dirty flush, repeated flush, load+flush on a clean line.
        run_op(3'b010, 32'h200, 32'h1234_5678, 4'b1111, 0);
        run_op(3'b100, 32'h200, 32'h0, 4'h0, 1);
        run_op(3'b100, 32'h200, 32'h0, 4'h0, 0);
        run_op(3'b101, 32'h300, 32'h0, 4'h0, 0);

        // Reset asserted while a fill is outstanding.
        ram_input_load    = 1'b1;
        ram_input_address = 32'h300;
        @(negedge clock);
        chk("rmf_busy", busy, 1'b1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rmf_rd_before", mem_read, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rmf_rd_drop", mem_read, 1'b0);
        chk("rmf_wr_drop", mem_write, 1'b0);
        chk("rmf_nohit", address_in_cache, 1'b0);
        @(posedge clock);
        #1;
        ram_input_load = 1'b0;
        #2 reset = 1'b1;
        m_valid = 1'b0; m_dirty = 1'b0; m_tag = 30'h0; m_data = 32'h0;
        @(posedge clock);
        #1;
        run_op(3'b001, 32'h300, 32'h0, 4'h0, 1);

        // Randomized requests over a small set of lines.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = 32'h100 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 1) << 2)
                + $urandom_range(0, 3);
            run_op(3'($urandom_range(0, 7)), a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_cache_line.md
# ram_cache_line

Single-entry, write-back, write-allocate cache leaf: the responder end of the `ram_input_*` / `address_in_cache` / `busy` / `load_value` protocol driven by the PLRU tree nodes. It holds one aligned xlen-bit word with tag, valid and dirty state. It answers hits combinationally. It services misses and flushes through a ready-handshaked port to the next memory level. Tree leaves instantiate one per way.

## Interface
- `rv64`, default 1, selects xlen = 64 (1) or 32 (0). Offset bits `ob` = rv64 ? 3 : 2. Tag width = xlen − ob.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately, independent of `clock`.
- `ram_input_load` / `ram_input_store` / `ram_input_flush`  in  1 each  request strobes from the parent node.
- `ram_input_address`  in  xlen  byte address; low `ob` bits ignored.
- `ram_input_store_value`  in  xlen  store data.
- `ram_input_store_mask`  in  xlen/8  byte enables for stores.
- `address_in_cache`  out  1  valid & stored tag == address tag.
- `busy`  out  1  request cannot complete this cycle.
- `load_value`  out  xlen  stored data word, always driven.
- `mem_read` / `mem_write`  out  1 each  backing-memory fill / writeback request.
- `mem_address`  out  xlen  {tag, ob zeros}.
- `mem_write_value`  out  xlen  stored data word.
- `mem_read_value`  in  xlen  fill data, sampled on the ready edge.
- `mem_ready`  in  1  memory accepts/completes the current request this cycle.

## Operation
- State: `valid`, `dirty`, `tag`, `data`, `fill_tag`, FSM ∈ {IDLE, WRITEBACK, FILL}. Reset: all 0, IDLE.
- Request priority when several strobes are high: flush > store > load. The parent must hold op, address, value and mask stable while `busy`=1.
- IDLE decisions (hit = `address_in_cache`):
  - Load hit: `busy`=0, `load_value`=data.
  - Store hit: `busy`=0. Merge masked bytes into data at the edge; dirty←1.
  - Load or store miss: `busy`=1. fill_tag←address tag. Next state is WRITEBACK if valid&dirty, else FILL.
  - Flush with valid&dirty: `busy`=1; next state WRITEBACK. Flush otherwise: `busy`=0, no change.
  - No request: `busy`=0, no change.
- WRITEBACK: `mem_write`=1, `mem_address`={tag,0}, `mem_write_value`=data, `busy`=1. On `mem_ready`: dirty←0. The next state is FILL if fill is pending (miss path), else IDLE (flush path).
- FILL: `mem_read`=1, `mem_address`={fill_tag,0}, `busy`=1, `address_in_cache`=0. On `mem_ready`: data←`mem_read_value`, tag←fill_tag, valid←1, dirty←0, next state IDLE.
- Completion: after returning to IDLE, the held request re-evaluates as a hit and completes with `busy`=0. Stores merge on that cycle.
- `mem_read` and `mem_write` are never both high. Both are 0 in IDLE.
- `busy` is combinational from state and inputs. The FSM never leaves IDLE without a request.

## Timing
- Hit load/store and clean flush: zero-cycle; `busy`=0 in the request cycle.
- Clean miss, ready-immediately memory: `busy` is high in cycles 0–1 (IDLE, FILL) and the request completes in cycle 2. Each memory wait cycle adds one cycle.
- Dirty miss: cycles 0 IDLE, 1 WRITEBACK, 2 FILL; completes in cycle 3, plus wait cycles.
- Dirty flush: cycle 0 IDLE, cycle 1 WRITEBACK; completes in cycle 2 with `busy`=0.
- While `mem_ready`=0, memory outputs hold constant.
- `reset` low mid-WRITEBACK or mid-FILL: the FSM returns to IDLE and `mem_read`/`mem_write` drop asynchronously. The line becomes invalid and the transaction is abandoned.
- A request dropped by the parent mid-FILL is still installed. A request dropped mid-WRITEBACK still finishes the writeback.

## Test plan
- rv64=0. After reset, load 0x100, memory ready immediately with 0xCAFEF00D → `busy` 1,1,0. `mem_read` is high one cycle at `mem_address` 0x100. Cycle 2: `address_in_cache`=1, `load_value`=0xCAFEF00D.
- Store 0x100 value 0x000000AA mask 0001 on that line → `busy`=0, no memory traffic. The next load returns 0xCAFEF0AA.
- With the line dirty, load 0x200 with `mem_ready` held low 2 cycles per request → `mem_write` to 0x100 with data 0xCAFEF0AA, then `mem_read` 0x200. `busy` is high for 7 cycles.
- Flush with the line dirty → one WRITEBACK, then `busy`=0. A second flush causes no `mem_write` and `busy`=0 immediately.
- Assert `reset` low mid-FILL → `mem_read` drops without waiting for `clock`. A subsequent load to the same address misses and refills.
- Load and flush asserted together on a clean line → flush wins: `busy`=0, no `mem_read`.
